// File: rtl/sme_add_seq.sv
// Masked add/sub sequencer: drives a shared Boolean-masked adder, refreshes
// its result shares with fresh randomness and hands them out on a handshake.
//
// Ports:
//   g_clk, g_reset                  clock, async active-high reset
//   req_valid/req_ready, req_sub    request handshake, 1 = subtract
//   req_rs1, req_rs2                operand Boolean shares (D x N)
//   flush                           cancel the in-flight operation
//   add_en, add_sub                 adder enable / subtract select
//   add_mxor, add_mand              adder operand shares
//   add_rd, add_rdy                 adder result shares / result valid
//   rng                             share-refresh randomness (RNGW x N)
//   rsp_valid/rsp_ready, rsp_rd     response handshake and refreshed shares
//   err                             sticky adder-timeout flag
module sme_add_seq #(
  parameter int D    = 3,
  parameter int N    = 32,
  parameter int RNGW = D - 1
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sub,
  input  logic [D-1:0][N-1:0]   req_rs1,
  input  logic [D-1:0][N-1:0]   req_rs2,
  input  logic                  flush,
  output logic                  add_en,
  output logic                  add_sub,
  output logic [D-1:0][N-1:0]   add_mxor,
  output logic [D-1:0][N-1:0]   add_mand,
  input  logic [D-1:0][N-1:0]   add_rd,
  input  logic                  add_rdy,
  input  logic [RNGW-1:0][N-1:0] rng,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [D-1:0][N-1:0]   rsp_rd,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [D-1:0][N-1:0] op1, op2, rsp_q;
  logic                sub_q;
  logic [3:0]          cnt;
  logic                err_q;

  logic [N-1:0]        rng_all;
  logic [D-1:0][N-1:0] refr;

  logic ld, clr_op, cap, clr_rsp, tmo, cnt_last;

  // The last share absorbs the XOR of every mask so that the
  // recombined value is unchanged by the refresh.
  always_comb begin
    rng_all = '0;
    for (int i = 0; i < RNGW; i++)
      rng_all = rng_all ^ rng[i];
    refr = '0;
    for (int i = 0; i < D - 1; i++)
      refr[i] = add_rd[i] ^ rng[i];
    refr[D-1] = add_rd[D-1] ^ rng_all;
  end

  // cnt holds the number of completed enabled cycles; the 15th
  // enabled cycle without add_rdy is the timeout point.
  assign cnt_last = (cnt == 4'd14);

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    clr_op   = 1'b0;
    cap      = 1'b0;
    clr_rsp  = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          ld       = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (add_rdy) begin
          if (flush) begin
            clr_op   = 1'b1;
            state_nx = IDLE;
          end else begin
            cap      = 1'b1;
            state_nx = HOLD;
          end
        end else if (cnt_last) begin
          tmo      = 1'b1;
          clr_op   = 1'b1;
          state_nx = IDLE;
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          clr_op   = 1'b1;
          clr_rsp  = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        // Adder keeps running until it reports, so its own
        // sequence counter returns to zero.
        if (add_rdy) begin
          clr_op   = 1'b1;
          state_nx = IDLE;
        end else if (cnt_last) begin
          tmo      = 1'b1;
          clr_op   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= IDLE;
      op1   <= '0;
      op2   <= '0;
      sub_q <= 1'b0;
      rsp_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld) begin
        op1   <= req_rs1;
        op2   <= req_rs2;
        sub_q <= req_sub;
      end else if (clr_op) begin
        op1   <= '0;
        op2   <= '0;
        sub_q <= 1'b0;
      end
      if (cap)
        rsp_q <= refr;
      else if (clr_rsp)
        rsp_q <= '0;
      if (ld)
        cnt <= '0;
      else if (state == RUN || state == DRAIN)
        cnt <= cnt + 4'd1;
      if (tmo)
        err_q <= 1'b1;
    end
  end

  assign req_ready = (state == IDLE);
  assign add_en    = (state == RUN) || (state == DRAIN);
  assign add_sub   = sub_q;
  assign add_mxor  = op1;
  assign add_mand  = op2;
  assign rsp_valid = (state == HOLD);
  assign rsp_rd    = rsp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sme_add_seq.sv
// Directed bench for sme_add_seq with a behavioural masked-adder model
// that reports in the sixth enabled cycle.
module tb_sme_add_seq;

  localparam int D = 3;
  localparam int N = 32;
  localparam int RNGW = 2;

  logic                g_clk = 1'b0;
  logic                g_reset;
  logic                req_valid, req_ready, req_sub;
  logic [D-1:0][N-1:0] req_rs1, req_rs2;
  logic                flush;
  logic                add_en, add_sub;
  logic [D-1:0][N-1:0] add_mxor, add_mand, add_rd;
  logic                add_rdy;
  logic [RNGW-1:0][N-1:0] rng;
  logic                rsp_valid, rsp_ready;
  logic [D-1:0][N-1:0] rsp_rd;
  logic                err;

  int n_chk = 0;
  int n_err = 0;

  logic [N-1:0] m1, m2;
  logic         add_off;
  int unsigned  acnt;

  always #5 g_clk = ~g_clk;

  sme_add_seq #(.D(D), .N(N), .RNGW(RNGW)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sub(req_sub), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .flush(flush), .add_en(add_en), .add_sub(add_sub),
    .add_mxor(add_mxor), .add_mand(add_mand),
    .add_rd(add_rd), .add_rdy(add_rdy), .rng(rng),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .err(err)
  );

  // adder model: result valid in the sixth enabled cycle
  always @(posedge g_clk or posedge g_reset) begin
    if (g_reset)      acnt <= 0;
    else if (add_rdy) acnt <= 0;
    else if (add_en)  acnt <= acnt + 1;
    else              acnt <= 0;
  end

  assign add_rdy = add_en && !add_off && (acnt == 5);

  always_comb begin
    logic [N-1:0] a, b, r;
    a = add_mxor[0] ^ add_mxor[1] ^ add_mxor[2];
    b = add_mand[0] ^ add_mand[1] ^ add_mand[2];
    r = add_sub ? a - b : a + b;
    add_rd = '0;
    add_rd[0] = r ^ m1 ^ m2;
    add_rd[1] = m1;
    add_rd[2] = m2;
  end

  task automatic chk(input string tag, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rxor();
    return rsp_rd[0] ^ rsp_rd[1] ^ rsp_rd[2];
  endfunction

  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input string tag);
    logic [N-1:0] ma, mb, mc, me;
    ma = $urandom; mb = $urandom; mc = $urandom; me = $urandom;
    @(negedge g_clk);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_sub   = sub;
    req_rs1[0] = a ^ ma ^ mb; req_rs1[1] = ma; req_rs1[2] = mb;
    req_rs2[0] = b ^ mc ^ me; req_rs2[1] = mc; req_rs2[2] = me;
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
    req_rs1 = '0;
    req_rs2 = '0;
    chk({tag, "_add_en"}, add_en, 1'b1);
    chk({tag, "_busy"}, req_ready, 1'b0);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic [N-1:0] exp,
                        input int hold, input string tag);
    logic [N-1:0] r0, r1, e0, e1, e2;
    logic [D-1:0][N-1:0] snap;
    r0 = $urandom; r1 = $urandom;
    rng[0] = r0; rng[1] = r1;
    m1 = $urandom; m2 = $urandom;
    accept(a, b, sub, tag);
    repeat (5) @(negedge g_clk);
    chk({tag, "_no_early"}, rsp_valid, 1'b0);
    @(negedge g_clk);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_en_off"}, add_en, 1'b0);
    e0 = exp ^ m1 ^ m2 ^ r0;
    e1 = m1 ^ r1;
    e2 = m2 ^ r0 ^ r1;
    chk({tag, "_xor"}, rxor(), exp);
    chk({tag, "_sh0"}, rsp_rd[0], e0);
    chk({tag, "_sh1"}, rsp_rd[1], e1);
    chk({tag, "_sh2"}, rsp_rd[2], e2);
    snap = rsp_rd;
    for (int k = 0; k < hold; k++) begin
      rng[0] = $urandom; rng[1] = $urandom;
      @(negedge g_clk);
      chk({tag, "_hold_v"}, rsp_valid, 1'b1);
      chk({tag, "_hold_rdy"}, req_ready, 1'b0);
      chk({tag, "_hold_d0"}, rsp_rd[0], snap[0]);
      chk({tag, "_hold_d2"}, rsp_rd[2], snap[2]);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    chk({tag, "_done_v"}, rsp_valid, 1'b0);
    chk({tag, "_done_rdy"}, req_ready, 1'b1);
    chk({tag, "_clr_rd"}, rsp_rd[0] | rsp_rd[1] | rsp_rd[2], '0);
    chk({tag, "_clr_op"}, add_mxor[0] | add_mand[1], '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g_reset   = 1'b1;
    req_valid = 1'b0;
    req_sub   = 1'b0;
    req_rs1   = '0;
    req_rs2   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    rng       = '0;
    m1        = '0;
    m2        = '0;
    add_off   = 1'b0;
    repeat (2) @(negedge g_clk);
    chk("rst_add_en", add_en, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rsp_rd", rxor() | rsp_rd[1], '0);
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("rst_req_ready", req_ready, 1'b1);

    run_op(32'h5, 32'h3, 1'b0, 32'h8, 0, "add");
    run_op(32'h5, 32'h3, 1'b1, 32'h2, 0, "sub");
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 0, "wrap");
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 3, "bp");

    // flush in second RUN cycle
    m1 = $urandom; m2 = $urandom;
    accept(32'h7, 32'h9, 1'b0, "fl");
    @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("fl_en", add_en, 1'b1);
      chk("fl_no_rsp", rsp_valid, 1'b0);
      chk("fl_busy", req_ready, 1'b0);
      if (k < 3) @(negedge g_clk);
    end
    @(negedge g_clk);
    chk("fl_idle", req_ready, 1'b1);
    chk("fl_en_off", add_en, 1'b0);
    chk("fl_no_rsp2", rsp_valid, 1'b0);
    chk("fl_clr_op", add_mxor[0] | add_mand[0], '0);
    run_op(32'hA, 32'h4, 1'b1, 32'h6, 0, "post_fl");

    // adder never reports
    add_off = 1'b1;
    accept(32'h1, 32'h2, 1'b0, "to");
    repeat (14) @(negedge g_clk);
    chk("to_err_early", err, 1'b0);
    chk("to_en", add_en, 1'b1);
    @(negedge g_clk);
    chk("to_err", err, 1'b1);
    chk("to_idle", req_ready, 1'b1);
    chk("to_no_rsp", rsp_valid, 1'b0);
    chk("to_clr_op", add_mxor[0] | add_mxor[1], '0);
    add_off = 1'b0;
    run_op(32'h10, 32'h20, 1'b0, 32'h30, 0, "after_to");
    chk("to_sticky", err, 1'b1);

    // reset in third RUN cycle
    accept(32'h3, 32'h3, 1'b0, "mr");
    repeat (2) @(negedge g_clk);
    chk("mr_en_pre", add_en, 1'b1);
    g_reset = 1'b1;
    #1;
    chk("mr_en", add_en, 1'b0);
    chk("mr_op", add_mxor[0] | add_mand[0], '0);
    chk("mr_rsp", rsp_valid, 1'b0);
    chk("mr_err", err, 1'b0);
    @(negedge g_clk);
    g_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge g_clk);
      chk("mr_rdy", req_ready, 1'b1);
      chk("mr_no_rsp", rsp_valid, 1'b0);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 0, "after_mr");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
